reg_file_ops: RTL and testbench
===============================

Name: reg_file_ops

Overview:
- Parametrised successor of the single 8-bit enable/reset register: a bank of DEPTH registers of WIDTH bits.
- One write port carries a per-write operation (load, increment, decrement, clear) and drives a registered carry/borrow flag.
- Two independent combinational read ports.
- Sits in the kt8v datapath as the general-purpose and pointer register bank feeding the ALU and address logic.

Parameters:
- WIDTH, 8, bits per register (range 2..32)
- DEPTH, 8, number of registers (power of two, 2..32); AW = $clog2(DEPTH), derived localparam
- RESET_VAL, 0, value loaded into every register on reset (truncated to WIDTH)
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- wr_en  in  1  perform the write-port operation this cycle
- wr_op  in  2  operation: LOAD=0, INC=1, DEC=2, CLR=3
- wr_addr  in  AW  target register
- wr_data  in  WIDTH  operand for LOAD; ignored for other ops
- rd_addr_a  in  AW  read port A address
- rd_data_a  out  WIDTH  read port A data, combinational
- rd_addr_b  in  AW  read port B address
- rd_data_b  out  WIDTH  read port B data, combinational
- carry  out  1  registered carry/borrow from the last effective write

Behaviour:
- Reset: at posedge with reset=1, all registers become RESET_VAL and carry becomes 0. Reset overrides wr_en in the same cycle. No asynchronous effect between edges.
- Write: at posedge with reset=0 and wr_en=1, reg[wr_addr] takes next = f(wr_op, reg[wr_addr], wr_data). Latency is 1 cycle; the new value is visible on the read ports after the edge.
- LOAD: next = wr_data; carry <= 0.
- INC: next = old + 1 mod 2^WIDTH; carry <= 1 if old == all-ones (wraps to 0), else 0.
- DEC: next = old - 1 mod 2^WIDTH; carry <= 1 if old == 0 (wraps to all-ones), else 0.
- CLR: next = 0; carry <= 0.
- wr_en=0: all registers and carry hold.
- ZERO_REG=1 with wr_addr=0: the write is discarded and carry holds. Reads of address 0 return 0 regardless of RESET_VAL.
- Reads: rd_data_x = reg[rd_addr_x], purely combinational. Ports A and B are fully independent, and both may address the same register.
- Read during write, same address (macro undefined): returns the old value until the edge.
- Only one write port exists, so there is no write-write conflict.
- Unused high address bits cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro: REG_FILE_OPS_BYPASS_EN
- Defined: when wr_en=1, reset=0, the write is effective, and rd_addr_x == wr_addr, rd_data_x returns the computed next value combinationally in the same cycle (write-through bypass).
- Defined, reset=1: no bypass; ports read the stored values.
- Undefined: no bypass; reads always return stored values.

Decomposition:
- Package kt8v_reg_pkg holds the op encoding constants OP_LOAD/OP_INC/OP_DEC/OP_CLR and the 2-bit op typedef.
- Sub-module reg_file_next_val: combinational; inputs op, old, data; outputs next value and carry.
  - It is shared by the write path and the bypass path.

Test Plan:
- Reset then read all addresses: with RESET_VAL=8'h5A, ports A and B return 8'h5A for every address; carry=0.
- LOAD 8'd10 to reg 3, then read: rd_data_a(3)=10 on the next cycle. Read of reg 3 in the write cycle = old value (no macro) or 10 (macro).
- INC reg 2 from 8'hFF: reg 2 = 8'h00 and carry=1. Next INC gives 8'h01 and carry=0. DEC from 8'h00 gives 8'hFF and carry=1.
- reset=1 and wr_en=1 (LOAD 8'h33 to reg 1) in the same cycle: reg 1 = RESET_VAL and carry=0. Then wr_en=0 for 3 cycles: all values held.
- ZERO_REG=1: LOAD 8'hAA to reg 0 with carry previously 1: reg 0 reads 0 on both ports and carry stays 1.
- Dual read: reg 4=8'h11, reg 5=8'h22. A=4 and B=5 return 11/22; A=B=5 both return 22. CLR reg 5 gives 0 and carry=0.

Source files
------------

// File: rtl/kt8v_reg_pkg.sv
// Shared encodings for the kt8v register bank write-port operations.
package kt8v_reg_pkg;

  localparam int unsigned OP_W = 2;

  // Write-port operation applied to the addressed register.
  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_CLR  = 2'd3
  } wr_op_t;

endpackage : kt8v_reg_pkg

// File: rtl/reg_file_next_val.sv
// Next-value and carry/borrow calculator for one write-port operation.
// Shared by the register write path and the optional read bypass.
module reg_file_next_val
  import kt8v_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  wr_op_t           i_op,
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_next,
  output logic             o_carry
);

  // Apply the operation; carry flags wrap-around on INC/DEC only.
  always_comb begin
    o_next  = i_old;
    o_carry = 1'b0;
    case (i_op)
      OP_LOAD: o_next = i_data;
      OP_INC: begin
        o_next  = i_old + WIDTH'(1);
        o_carry = &i_old;
      end
      OP_DEC: begin
        o_next  = i_old - WIDTH'(1);
        o_carry = ~|i_old;
      end
      OP_CLR:  o_next = '0;
      default: o_next = i_old;
    endcase
  end

endmodule : reg_file_next_val

// File: rtl/reg_file_ops.sv
// General-purpose / pointer register bank: DEPTH x WIDTH registers, one
// operation write port with registered carry, two combinational read ports.
// Optional write-through read bypass: define REG_FILE_OPS_BYPASS_EN.
module reg_file_ops
  import kt8v_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned ZERO_REG  = 0,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             carry
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_carry;

  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_zero_hit;
  logic             w_wr_eff;

  assign w_old      = r_regs[wr_addr];
  assign w_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  // A write only takes effect outside reset and never to a hardwired-zero reg 0.
  assign w_wr_eff   = wr_en && !reset && !w_zero_hit;

  reg_file_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .i_op    (wr_op_t'(wr_op)),
    .i_old   (w_old),
    .i_data  (wr_data),
    .o_next  (w_next),
    .o_carry (w_carry)
  );

  // Register bank and carry flag update; reset overrides any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= WIDTH'(RESET_VAL);
      end
      r_carry <= 1'b0;
    end else if (w_wr_eff) begin
      r_regs[wr_addr] <= w_next;
      r_carry         <= w_carry;
    end
  end

  assign carry = r_carry;

  // Read port A: hardwired zero, optional bypass, else stored value.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
`ifdef REG_FILE_OPS_BYPASS_EN
    if (w_wr_eff && (rd_addr_a == wr_addr)) begin
      rd_data_a = w_next;
    end
`endif
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
  end

  // Read port B: same rules as port A, fully independent address.
  always_comb begin
    rd_data_b = r_regs[rd_addr_b];
`ifdef REG_FILE_OPS_BYPASS_EN
    if (w_wr_eff && (rd_addr_b == wr_addr)) begin
      rd_data_b = w_next;
    end
`endif
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
  end

endmodule : reg_file_ops

// File: tb/tb_reg_file_ops.sv
// Randomized and directed bench for reg_file_ops: two instances (ZERO_REG 0/1)
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_ops;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned RV = 'h5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [1:0]    wr_op;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [1:0][W-1:0] rd_a;
  logic [1:0][W-1:0] rd_b;
  logic [1:0]        cy;

  int n_checks = 0;
  int n_fail   = 0;

  int mem [2][D];
  bit mcarry [2];
  bit model_valid = 0;

  always #5 clk = ~clk;

  reg_file_ops #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[0]), .carry(cy[0])
  );

  reg_file_ops #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[1]), .carry(cy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: values as integers modulo 256.
  function automatic int model_next(input int op, input int old, input int data, output bit c);
    c = 1'b0;
    case (op)
      0: return data;
      1: begin c = (old == 255); return (old + 1) % 256; end
      2: begin c = (old == 0);   return (old + 255) % 256; end
      default: return 0;
    endcase
  endfunction

  function automatic bit write_takes(input int inst, input bit rst, input bit en, input int wa);
    return !rst && en && !(inst == 1 && wa == 0);
  endfunction

  function automatic int exp_read(input int inst, input int a, input bit rst, input bit en,
                                  input int op, input int wa, input int data);
    bit c;
    if (inst == 1 && a == 0) return 0;
`ifdef REG_FILE_OPS_BYPASS_EN
    if (write_takes(inst, rst, en, wa) && a == wa) return model_next(op, mem[inst][wa], data, c);
`endif
    return mem[inst][a];
  endfunction

  // One clock cycle: drive, check reads before the edge, update model, check carry.
  task automatic cycle(input bit rst, input bit en, input int op, input int wa,
                       input int data, input int ra, input int rb);
    bit c;
    int v;
    @(negedge clk);
    reset     = rst;
    wr_en     = en;
    wr_op     = 2'(op);
    wr_addr   = AW'(wa);
    wr_data   = W'(data);
    rd_addr_a = AW'(ra);
    rd_addr_b = AW'(rb);
    #1;
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d rdA[%0d]", i, ra), 32'(rd_a[i]), 32'(exp_read(i, ra, rst, en, op, wa, data)));
        check($sformatf("u%0d rdB[%0d]", i, rb), 32'(rd_b[i]), 32'(exp_read(i, rb, rst, en, op, wa, data)));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < int'(D); k++) mem[i][k] = int'(RV);
        mcarry[i] = 1'b0;
      end else if (write_takes(i, rst, en, wa)) begin
        v = model_next(op, mem[i][wa], data, c);
        mem[i][wa] = v;
        mcarry[i]  = c;
      end
    end
    if (rst) model_valid = 1'b1;
    #1;
    if (model_valid) begin
      for (int i = 0; i < 2; i++) check($sformatf("u%0d carry", i), 32'(cy[i]), 32'(mcarry[i]));
    end
  endtask

  initial begin
    int op, data;
    reset = 1'b1; wr_en = 1'b0; wr_op = '0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;

    // Reset, then sweep every address on both ports.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < int'(D); a++) cycle(0, 0, 0, 0, 0, a, 7 - a);

    // LOAD 10 to reg 3, read during and after the write.
    cycle(0, 1, 0, 3, 10, 3, 3);
    cycle(0, 0, 0, 0, 0, 3, 3);

    // INC wrap from FF, INC again, CLR then DEC wrap from 00.
    cycle(0, 1, 0, 2, 'hFF, 2, 2);
    cycle(0, 1, 1, 2, 0, 2, 2);
    cycle(0, 1, 1, 2, 0, 2, 2);
    cycle(0, 1, 3, 2, 0, 2, 2);
    cycle(0, 1, 2, 2, 0, 2, 2);
    cycle(0, 0, 0, 0, 0, 2, 3);

    // Reset collides with a LOAD, then three idle cycles.
    cycle(1, 1, 0, 1, 'h33, 1, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 'h77, 1, 3);

    // Carry to 1, then LOAD AA to reg 0.
    cycle(0, 1, 3, 6, 0, 6, 0);
    cycle(0, 1, 2, 6, 0, 6, 0);
    cycle(0, 1, 0, 0, 'hAA, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Dual read, same-address read, CLR.
    cycle(0, 1, 0, 4, 'h11, 4, 5);
    cycle(0, 1, 0, 5, 'h22, 4, 5);
    cycle(0, 0, 0, 0, 0, 4, 5);
    cycle(0, 0, 0, 0, 0, 5, 5);
    cycle(0, 1, 3, 5, 0, 5, 5);
    cycle(0, 0, 0, 0, 0, 5, 5);

    // Randomized traffic with occasional reset and boundary operands.
    for (int n = 0; n < 400; n++) begin
      op   = int'($urandom_range(0, 3));
      data = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) data = 'hFF;
      if ($urandom_range(0, 7) == 0) data = 0;
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), op,
            int'($urandom_range(0, D - 1)), data,
            int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file_ops
